// File: rtl/wdf_halfband_interp.sv
// Polyphase wave-digital lattice halfband interpolator (1:2).
// One shared adaptor steps through all allpass sections.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   din/din_vld/din_rdy  input sample handshake (D_IN bits)
//   alpha_a, alpha_b     Q1.10 section coefficients, 11 bits each
//   dout/dout_phase      output sample; phase 0 = branch A, 1 = B
//   dout_vld/dout_rdy    output handshake
// Build option: define WDF_SAT_EN to saturate y and s_next
// instead of wrapping them.
module wdf_halfband_interp #(
    parameter int D_IN  = 10,
    parameter int D_INT = 12,
    parameter int NA    = 2,
    parameter int NB    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_IN-1:0]      din,
    input  logic                 din_vld,
    output logic                 din_rdy,
    input  logic [11*NA-1:0]     alpha_a,
    input  logic [11*NB-1:0]     alpha_b,
    output logic [D_INT-1:0]     dout,
    output logic                 dout_phase,
    output logic                 dout_vld,
    input  logic                 dout_rdy
);

    localparam int NS = NA + NB;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int SW = D_INT + 3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC_A = 3'd1;
    localparam logic [2:0] CALC_B = 3'd2;
    localparam logic [2:0] OUT0   = 3'd3;
    localparam logic [2:0] OUT1   = 3'd4;

    logic [2:0]              state;
    logic [IW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    last;
    logic [D_INT-1:0]        st [NS];
    logic [D_INT-1:0]        xs;
    logic [D_INT-1:0]        xc;
    logic [D_INT-1:0]        ya;
    logic [D_INT-1:0]        yb;
    logic [D_INT-1:0]        cs;
    logic [D_INT-1:0]        y;
    logic [D_INT-1:0]        s_nxt;
    logic [11*NS-1:0]        coef_all;
    logic signed [10:0]      coef;
    logic signed [D_INT:0]   d;
    logic signed [D_INT+11:0] p;
    logic signed [D_INT+11:0] pr;
    logic [D_INT+1:0]        t;
    logic [SW-1:0]           y_sum;
    logic [SW-1:0]           s_sum;
    logic                    unused_bits;

    assign din_rdy    = (state == IDLE);
    assign dout_vld   = (state == OUT0) || (state == OUT1);
    assign dout_phase = (state == OUT1);

    // Section states of both branches share one array:
    // branch B sections live at NA..NS-1.
    assign idx = (state == CALC_B) ? cnt + IW'(NA) : cnt;
    assign last = (state == CALC_B) ? (cnt == IW'(NB - 1))
                                    : (cnt == IW'(NA - 1));

    assign coef_all = {alpha_b, alpha_a};
    assign coef     = coef_all[idx*11 +: 11];
    assign cs       = st[idx];

    // Adaptor: t = floor((alpha*(s-x) + 512) / 1024)
    assign d  = {cs[D_INT-1], cs} - {xc[D_INT-1], xc};
    assign p  = coef * d;
    assign pr = p + $signed((D_INT + 12)'(512));
    assign t  = pr[D_INT+11:10];

    assign y_sum = {{3{cs[D_INT-1]}}, cs} + {t[D_INT+1], t};
    assign s_sum = {{3{xc[D_INT-1]}}, xc} + {t[D_INT+1], t};

`ifdef WDF_SAT_EN
    function automatic logic [D_INT-1:0] sat(input logic [SW-1:0] v);
        if ((&v[SW-1:D_INT-1]) || (~|v[SW-1:D_INT-1]))
            sat = v[D_INT-1:0];
        else if (v[SW-1])
            sat = {1'b1, {(D_INT-1){1'b0}}};
        else
            sat = {1'b0, {(D_INT-1){1'b1}}};
    endfunction

    assign y           = sat(y_sum);
    assign s_nxt       = sat(s_sum);
    assign unused_bits = ^pr[9:0];
`else
    assign y           = y_sum[D_INT-1:0];
    assign s_nxt       = s_sum[D_INT-1:0];
    assign unused_bits = ^{pr[9:0], y_sum[SW-1:D_INT],
                           s_sum[SW-1:D_INT]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            xs    <= '0;
            xc    <= '0;
            ya    <= '0;
            yb    <= '0;
            dout  <= '0;
            for (int i = 0; i < NS; i++)
                st[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_vld) begin
                        xs    <= D_INT'($signed(din));
                        xc    <= D_INT'($signed(din));
                        cnt   <= '0;
                        state <= CALC_A;
                    end
                end
                CALC_A: begin
                    st[idx] <= s_nxt;
                    if (last) begin
                        ya    <= y;
                        xc    <= xs;
                        cnt   <= '0;
                        state <= CALC_B;
                    end else begin
                        xc  <= y;
                        cnt <= cnt + IW'(1);
                    end
                end
                CALC_B: begin
                    st[idx] <= s_nxt;
                    if (last) begin
                        yb    <= y;
                        dout  <= ya;
                        cnt   <= '0;
                        state <= OUT0;
                    end else begin
                        xc  <= y;
                        cnt <= cnt + IW'(1);
                    end
                end
                OUT0: begin
                    if (dout_rdy) begin
                        dout  <= yb;
                        state <= OUT1;
                    end
                end
                OUT1: begin
                    if (dout_rdy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wdf_halfband_interp.sv
// Self-checking bench for wdf_halfband_interp.
// Integer reference model of the lattice; honours WDF_SAT_EN.
module tb_wdf_halfband_interp;

    localparam int D_IN  = 10;
    localparam int D_INT = 12;
    localparam int NA    = 2;
    localparam int NB    = 2;
    localparam int NS    = NA + NB;
    localparam int LAT   = NA + NB + 1;
    localparam int PER   = NA + NB + 3;
    localparam longint HI  = 2**(D_INT-1) - 1;
    localparam longint LO  = -(2**(D_INT-1));
    localparam longint MOD = 2**D_INT;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [D_IN-1:0]    din = '0;
    logic               din_vld = 1'b0;
    logic               din_rdy;
    logic [11*NA-1:0]   alpha_a = '0;
    logic [11*NB-1:0]   alpha_b = '0;
    logic [D_INT-1:0]   dout;
    logic               dout_phase;
    logic               dout_vld;
    logic               dout_rdy = 1'b1;

    wdf_halfband_interp #(
        .D_IN(D_IN), .D_INT(D_INT), .NA(NA), .NB(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .alpha_a(alpha_a), .alpha_b(alpha_b),
        .dout(dout), .dout_phase(dout_phase),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_q[$];
    int acc_t[$];
    int out_v[$];
    int out_p[$];
    int out_t[$];
    longint ms[NS];

    // Transfers are logged mid-cycle, when all signals are settled.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && din_vld && din_rdy) begin
            acc_q.push_back(int'($signed(din)));
            acc_t.push_back(cyc);
        end
        if (rst_n && dout_vld && dout_rdy) begin
            out_v.push_back(int'($signed(dout)));
            out_p.push_back(int'(dout_phase));
            out_t.push_back(cyc);
        end
    end

    function automatic longint floor1024(longint n);
        longint q;
        q = n / 1024;
        if (n < 0 && q * 1024 != n)
            q = q - 1;
        return q;
    endfunction

    function automatic longint fit(longint v);
        longint m;
`ifdef WDF_SAT_EN
        m = (v > HI) ? HI : ((v < LO) ? LO : v);
`else
        m = v % MOD;
        if (m < 0) m = m + MOD;
        if (m > HI) m = m - MOD;
`endif
        return m;
    endfunction

    function automatic longint sec(int k, longint x, longint a);
        longint t;
        longint y;
        t = floor1024(a * (ms[k] - x) + 512);
        y = fit(ms[k] + t);
        ms[k] = fit(x + t);
        return y;
    endfunction

    task automatic model(input int x, output int ya, output int yb);
        longint y;
        y = x;
        for (int k = 0; k < NA; k++)
            y = sec(k, y, longint'($signed(alpha_a[k*11 +: 11])));
        ya = int'(y);
        y = x;
        for (int k = 0; k < NB; k++)
            y = sec(NA + k, y, longint'($signed(alpha_b[k*11 +: 11])));
        yb = int'(y);
    endtask

    task automatic clear_all();
        acc_q.delete();
        acc_t.delete();
        out_v.delete();
        out_p.delete();
        out_t.delete();
        for (int k = 0; k < NS; k++) ms[k] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_alpha();
        for (int k = 0; k < NA; k++)
            alpha_a[k*11 +: 11] = 11'($urandom_range(0, 2047));
        for (int k = 0; k < NB; k++)
            alpha_b[k*11 +: 11] = 11'($urandom_range(0, 2047));
    endtask

    // Called just after a rising edge; returns just after the
    // edge that took the sample.
    task automatic send(input int x, input bit hold);
        int n = 0;
        din = D_IN'(x);
        din_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (din_rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got din_rdy=0 need 1");
                din_vld = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        if (!hold) din_vld = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int k = 0;
        while (out_v.size() < n && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (out_v.size() < n) begin
            checks++;
            errors++;
            $display("FAIL out_timeout got %0d outputs need %0d",
                     out_v.size(), n);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (din_rdy !== 1'b1 || dout_vld !== 1'b0 ||
            dout !== '0 || dout_phase !== 1'b0) begin
            errors++;
            $display("FAIL reset got rdy=%b vld=%b dout=%0d ph=%b need 1 0 0 0",
                     din_rdy, dout_vld, dout, dout_phase);
        end
        do_reset();
    endtask

    task automatic test_delay();
        int expv[4] = '{0, 0, 100, 0};
        int xs[4] = '{100, 0, 0, 0};
        do_reset();
        alpha_a = '0;
        alpha_b = '0;
        for (int i = 0; i < 4; i++) send(xs[i], 1'b0);
        wait_outs(8);
        if (out_v.size() >= 8) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_v[2*i] !== expv[i] || out_p[2*i] !== 0) begin
                    errors++;
                    $display("FAIL delay_ph0[%0d] got %0d/%0d need %0d/0",
                             i, out_v[2*i], out_p[2*i], expv[i]);
                end
                checks++;
                if (out_v[2*i+1] !== expv[i] || out_p[2*i+1] !== 1) begin
                    errors++;
                    $display("FAIL delay_ph1[%0d] got %0d/%0d need %0d/1",
                             i, out_v[2*i+1], out_p[2*i+1], expv[i]);
                end
            end
            checks++;
            if (out_t[0] - acc_t[0] !== LAT) begin
                errors++;
                $display("FAIL latency got %0d need %0d",
                         out_t[0] - acc_t[0], LAT);
            end
        end
    endtask

    task automatic test_rounding();
        int ya, yb;
        int exp0[3] = '{0, -50, 75};
        do_reset();
        alpha_a = '0;
        alpha_b = '0;
        alpha_a[10:0] = 11'd512;
        send(100, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 1'b0);
        wait_outs(10);
        if (out_v.size() >= 10) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_v[2*i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL round_const[%0d] got %0d need %0d",
                             i, out_v[2*i], exp0[i]);
                end
            end
            for (int i = 0; i < acc_q.size(); i++) begin
                model(acc_q[i], ya, yb);
                checks++;
                if (out_v[2*i] !== ya || out_v[2*i+1] !== yb) begin
                    errors++;
                    $display("FAIL round[%0d] got %0d,%0d need %0d,%0d",
                             i, out_v[2*i], out_v[2*i+1], ya, yb);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int ya, yb, x, n;
        do_reset();
        rand_alpha();
        dout_rdy = 1'b0;
        x = $urandom_range(0, 1023) - 512;
        send(x, 1'b0);
        model(x, ya, yb);
        n = 0;
        while (!dout_vld && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (int'($signed(dout)) !== ya || dout_phase !== 1'b0 ||
                dout_vld !== 1'b1 || din_rdy !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got %0d ph%b v%b r%b need %0d ph0 v1 r0",
                         i, $signed(dout), dout_phase, dout_vld,
                         din_rdy, ya);
            end
        end
        @(posedge clk); #1;
        dout_rdy = 1'b1;
        wait_outs(2);
        if (out_v.size() >= 2) begin
            checks++;
            if (out_v[0] !== ya || out_p[0] !== 0 ||
                out_v[1] !== yb || out_p[1] !== 1) begin
                errors++;
                $display("FAIL bp_data got %0d/%0d %0d/%0d need %0d/0 %0d/1",
                         out_v[0], out_p[0], out_v[1], out_p[1], ya, yb);
            end
            checks++;
            if (out_t[1] - out_t[0] !== 1) begin
                errors++;
                $display("FAIL bp_gap got %0d need 1",
                         out_t[1] - out_t[0]);
            end
        end
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL vld_drop got %b need 0", dout_vld);
        end
    endtask

    task automatic test_back_to_back();
        int ya, yb;
        do_reset();
        rand_alpha();
        for (int i = 0; i < 6; i++)
            send($urandom_range(0, 1023) - 512, 1'b1);
        din_vld = 1'b0;
        wait_outs(12);
        checks++;
        if (acc_q.size() !== 6) begin
            errors++;
            $display("FAIL b2b_accepts got %0d need 6", acc_q.size());
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++;
            if (acc_t[i] - acc_t[i-1] !== PER) begin
                errors++;
                $display("FAIL b2b_period[%0d] got %0d need %0d",
                         i, acc_t[i] - acc_t[i-1], PER);
            end
        end
        if (out_v.size() >= 2 * acc_q.size()) begin
            for (int i = 0; i < acc_q.size(); i++) begin
                model(acc_q[i], ya, yb);
                checks++;
                if (out_v[2*i] !== ya || out_v[2*i+1] !== yb) begin
                    errors++;
                    $display("FAIL b2b[%0d] got %0d,%0d need %0d,%0d",
                             i, out_v[2*i], out_v[2*i+1], ya, yb);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ya, yb;
        int xs[4] = '{100, 0, 0, 0};
        int exp0[3] = '{0, -50, 75};
        do_reset();
        alpha_a = '0;
        alpha_b = '0;
        alpha_a[10:0] = 11'd512;
        alpha_b[10:0] = 11'd300;
        send(400, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got vld=%b rdy=%b need 0 1",
                     dout_vld, din_rdy);
        end
        clear_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(xs[i], 1'b0);
        wait_outs(8);
        if (out_v.size() >= 8) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_v[2*i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL mid_const[%0d] got %0d need %0d",
                             i, out_v[2*i], exp0[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                model(acc_q[i], ya, yb);
                checks++;
                if (out_v[2*i] !== ya || out_v[2*i+1] !== yb) begin
                    errors++;
                    $display("FAIL mid[%0d] got %0d,%0d need %0d,%0d",
                             i, out_v[2*i], out_v[2*i+1], ya, yb);
                end
            end
        end
    endtask

    task automatic test_sat();
        int ya, yb;
        do_reset();
        alpha_a = '0;
        alpha_b = '0;
        alpha_a[10:0] = 11'h400;
        for (int i = 0; i < 6; i++) send(-512, 1'b0);
        wait_outs(12);
        if (out_v.size() >= 12) begin
            for (int i = 0; i < 6; i++) begin
                model(acc_q[i], ya, yb);
                checks++;
                if (out_v[2*i] !== ya || out_v[2*i+1] !== yb) begin
                    errors++;
                    $display("FAIL sat[%0d] got %0d,%0d need %0d,%0d",
                             i, out_v[2*i], out_v[2*i+1], ya, yb);
                end
            end
        end
    endtask

    task automatic test_random();
        int ya, yb;
        bit done = 1'b0;
        do_reset();
        rand_alpha();
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    if (i % 5 == 0) send(511, 1'b0);
                    else if (i % 7 == 0) send(-512, 1'b0);
                    else send($urandom_range(0, 1023) - 512, 1'b0);
                end
                wait_outs(60);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    dout_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_rdy = 1'b1;
        if (out_v.size() >= 2 * acc_q.size()) begin
            for (int i = 0; i < acc_q.size(); i++) begin
                model(acc_q[i], ya, yb);
                checks++;
                if (out_v[2*i] !== ya || out_p[2*i] !== 0 ||
                    out_v[2*i+1] !== yb || out_p[2*i+1] !== 1) begin
                    errors++;
                    $display("FAIL rand[%0d] got %0d,%0d need %0d,%0d",
                             i, out_v[2*i], out_v[2*i+1], ya, yb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_delay();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sat();
        test_random();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
